regfile_sb: RTL and testbench
=============================

# regfile_sb

Parametrised multi-port register file for the RISC datapath, generalising the 8-bit × 16 single-write, dual-read file. It provides NRD asynchronous read ports and two write ports: port 0 for ALU writeback, port 1 for load/memory writeback. It also keeps a per-register scoreboard (busy bit) so decode can detect load-use hazards. It sits between decode (read addresses, scoreboard set) and the writeback stage.

## Interface
- DW, 8, data width in bits
- DEPTH, 16, number of registers, power of two ≥ 2
- AW, $clog2(DEPTH), address width (derived, not overridden)
- NRD, 2, number of read ports, 1..4
- ZERO_REG, 1, 1 = register 0 reads as zero and ignores writes and scoreboard sets

- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous, active-low reset
- rd_addr  in  NRD*AW  read addresses; port i uses bits [i*AW +: AW]
- rd_data  out  NRD*DW  read data, port i at [i*DW +: DW]
- rd_busy  out  NRD  scoreboard bit of the register addressed by port i
- we0, wa0, wd0  in  1, AW, DW  ALU write enable, address, data
- we1, wa1, wd1  in  1, AW, DW  load write enable, address, data; clears the busy bit
- sb_set, sb_addr  in  1, AW  mark register sb_addr pending (load issued)
- wr_collide  out  1  registered flag: previous cycle had we0 & we1 to the same address
- busy_any  out  1  OR of all busy bits (registered state, combinational OR)

## Operation
- Storage: DEPTH × DW flops; busy: DEPTH flops.
- Writes at posedge clk. If we0 & we1 & (wa0 == wa1), port 1 data is stored and port 0 data is discarded. wr_collide is then 1 for the following cycle and 0 otherwise.
- Busy bit r:
  - sb_set & sb_addr == r sets it.
  - we1 & wa1 == r clears it.
  - Both in the same cycle to the same r: set wins, because a new load supersedes the old one.
  - we0 never changes busy bits.
- ZERO_REG = 1:
  - writes to address 0 are dropped and do not count as collisions;
  - sb_set to address 0 is ignored;
  - rd_data reads 0 and rd_busy reads 0 for address 0.
- ZERO_REG = 0: register 0 is ordinary.
- Reads are combinational from rd_addr. All NRD ports are independent, and any ports may alias.
- Addresses are always in range, since DEPTH = 2^AW. No wrap logic is needed.

## Timing
- Reset (rst_n low, asynchronous): all registers = 0, all busy = 0, wr_collide = 0. rd_data then reads 0 for every address.
- Release of rst_n is synchronised externally. The first write is accepted at the first posedge with rst_n high.
- Read latency is 0 cycles (combinational).
- Write-to-read latency without bypass: write at edge N is visible on reads from just after edge N.
- Scoreboard: sb_set at edge N gives rd_busy = 1 after edge N. we1 at edge M gives rd_busy = 0 after edge M.
- Reset asserted mid-operation aborts all pending loads, so every busy bit clears.

## Configuration
- REGFILE_BYPASS_EN defined:
  - each read port forwards current-cycle write data when the read address matches an active write;
  - we1 has priority over we0;
  - ZERO_REG rules still apply;
  - rd_busy for a register being cleared by we1 this cycle reads 0;
  - a same-cycle sb_set to that register still makes it read 1.
- Not defined: reads and rd_busy reflect stored state only.

## Structure
- regfile_pkg: default DW/DEPTH/NRD constants, and a typedef for the write-request bundle {we, wa, wd}.
- Sub-module regfile_scoreboard:
  - holds the DEPTH busy flops and the set/clear priority;
  - exports the busy vector;
  - the read-port mux and bypass stay in regfile_sb.

## Test plan
- Reset: write 0xA5 to r3, assert rst_n low mid-cycle -> rd_data for r3 = 0x00 immediately; busy_any = 0.
- Dual write collision: we0 (r5, 0x11) and we1 (r5, 0x22) at the same edge -> r5 = 0x22, wr_collide = 1 for one cycle, then 0.
- Zero register: we0 (r0, 0xFF) and sb_set r0 -> rd_data(r0) = 0x00, rd_busy = 0, wr_collide = 0.
- Scoreboard:
  - sb_set r7 -> rd_busy = 1 on all ports addressing r7.
  - we0 (r7, 0x33) -> data 0x33, still busy.
  - we1 (r7, 0x44) -> busy 0, data 0x44.
- Set/clear same cycle: r9 busy, then we1 (r9) and sb_set r9 together -> r9 stays busy with the new data.
- Bypass (REGFILE_BYPASS_EN): we1 (r2, 0x5C) with rd_addr port 1 = r2 in the same cycle -> rd_data = 0x5C before the edge. Without the macro -> old value.

Source files
------------

// File: rtl/regfile_pkg.sv
// Shared defaults and the write-request bundle for the regfile_sb register file.
package regfile_pkg;

  localparam int DEF_DW    = 8;
  localparam int DEF_DEPTH = 16;
  localparam int DEF_AW    = $clog2(DEF_DEPTH);
  localparam int DEF_NRD   = 2;

  typedef struct packed {
    logic              we;
    logic [DEF_AW-1:0] wa;
    logic [DEF_DW-1:0] wd;
  } wr_req_t;

endpackage

// File: rtl/regfile_sb_if.sv
// Decode/writeback-facing bundle of regfile_sb: read ports, two write ports, scoreboard set.
interface regfile_sb_if
  import regfile_pkg::*;
#(
  parameter int DW  = DEF_DW,
  parameter int AW  = DEF_AW,
  parameter int NRD = DEF_NRD
);

  logic [NRD*AW-1:0] rd_addr;
  logic [NRD*DW-1:0] rd_data;
  logic [NRD-1:0]    rd_busy;
  logic              we0;
  logic [AW-1:0]     wa0;
  logic [DW-1:0]     wd0;
  logic              we1;
  logic [AW-1:0]     wa1;
  logic [DW-1:0]     wd1;
  logic              sb_set;
  logic [AW-1:0]     sb_addr;
  logic              wr_collide;
  logic              busy_any;

  modport master (
    output rd_addr, we0, wa0, wd0, we1, wa1, wd1, sb_set, sb_addr,
    input  rd_data, rd_busy, wr_collide, busy_any
  );

  modport slave (
    input  rd_addr, we0, wa0, wd0, we1, wa1, wd1, sb_set, sb_addr,
    output rd_data, rd_busy, wr_collide, busy_any
  );

endinterface

// File: rtl/regfile_scoreboard.sv
// Per-register busy bits for load-use hazard detection; a new load (set) beats a
// completing load (clear) on the same register in the same cycle.
module regfile_scoreboard #(
  parameter int DEPTH    = 16,
  parameter int AW       = 4,
  parameter int ZERO_REG = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_set,
  input  logic [AW-1:0]    i_set_addr,
  input  logic             i_clr,
  input  logic [AW-1:0]    i_clr_addr,
  output logic [DEPTH-1:0] o_busy
);

  localparam bit ZR = (ZERO_REG != 0);

  logic [DEPTH-1:0] r_busy;
  logic [DEPTH-1:0] w_busy_nxt;

  // Next busy state: set wins over clear, register 0 is never busy when hardwired
  always_comb begin
    w_busy_nxt = r_busy;
    for (int r = 0; r < DEPTH; r++) begin
      if (ZR && (r == 0)) begin
        w_busy_nxt[r] = 1'b0;
      end else if (i_set && (i_set_addr == AW'(r))) begin
        w_busy_nxt[r] = 1'b1;
      end else if (i_clr && (i_clr_addr == AW'(r))) begin
        w_busy_nxt[r] = 1'b0;
      end else begin
        w_busy_nxt[r] = r_busy[r];
      end
    end
  end

  // Busy flops; reset aborts every pending load
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_busy <= {DEPTH{1'b0}};
    end else begin
      r_busy <= w_busy_nxt;
    end
  end

  assign o_busy = r_busy;

endmodule

// File: rtl/regfile_sb.sv
// Multi-port register file with ALU/load write ports and load scoreboard.
// Optional same-cycle write-to-read forwarding: define REGFILE_BYPASS_EN.
module regfile_sb
  import regfile_pkg::*;
#(
  parameter int DW       = DEF_DW,
  parameter int DEPTH    = DEF_DEPTH,
  parameter int NRD      = DEF_NRD,
  parameter int ZERO_REG = 1
) (
  input logic         clk,
  input logic         rst_n,
  regfile_sb_if.slave bus
);

  localparam int AW = $clog2(DEPTH);
  localparam bit ZR = (ZERO_REG != 0);

  logic [DW-1:0]    r_mem [DEPTH];
  logic             r_collide;
  logic [DEPTH-1:0] w_busy;
  logic             w_we0;
  logic             w_we1;
  logic             w_collide;
  logic [AW-1:0]    w_ra;
  logic [DW-1:0]    w_rd;
  logic             w_rb;

  // Writes aimed at a hardwired zero register vanish before they can collide
  assign w_we0     = bus.we0 & ~(ZR & (bus.wa0 == {AW{1'b0}}));
  assign w_we1     = bus.we1 & ~(ZR & (bus.wa1 == {AW{1'b0}}));
  assign w_collide = w_we0 & w_we1 & (bus.wa0 == bus.wa1);

  // Storage and collision flag; port 1 is written last so the load data wins
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int r = 0; r < DEPTH; r++) begin
        r_mem[r] <= {DW{1'b0}};
      end
      r_collide <= 1'b0;
    end else begin
      r_collide <= w_collide;
      if (w_we0) begin
        r_mem[bus.wa0] <= bus.wd0;
      end
      if (w_we1) begin
        r_mem[bus.wa1] <= bus.wd1;
      end
    end
  end

  regfile_scoreboard #(
    .DEPTH    (DEPTH),
    .AW       (AW),
    .ZERO_REG (ZERO_REG)
  ) u_sb (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_set      (bus.sb_set),
    .i_set_addr (bus.sb_addr),
    .i_clr      (bus.we1),
    .i_clr_addr (bus.wa1),
    .o_busy     (w_busy)
  );

  // Independent combinational read ports, optionally forwarding this cycle's writes
  always_comb begin
    bus.rd_data = {NRD*DW{1'b0}};
    bus.rd_busy = {NRD{1'b0}};
    w_ra        = {AW{1'b0}};
    w_rd        = {DW{1'b0}};
    w_rb        = 1'b0;
    for (int p = 0; p < NRD; p++) begin
      w_ra = bus.rd_addr[p*AW +: AW];
`ifdef REGFILE_BYPASS_EN
      if (w_we1 && (bus.wa1 == w_ra)) begin
        w_rd = bus.wd1;
      end else if (w_we0 && (bus.wa0 == w_ra)) begin
        w_rd = bus.wd0;
      end else begin
        w_rd = r_mem[w_ra];
      end
      if (bus.sb_set && (bus.sb_addr == w_ra)) begin
        w_rb = 1'b1;
      end else if (bus.we1 && (bus.wa1 == w_ra)) begin
        w_rb = 1'b0;
      end else begin
        w_rb = w_busy[w_ra];
      end
`else
      w_rd = r_mem[w_ra];
      w_rb = w_busy[w_ra];
`endif
      if (ZR && (w_ra == {AW{1'b0}})) begin
        w_rd = {DW{1'b0}};
        w_rb = 1'b0;
      end else begin
        w_rd = w_rd;
        w_rb = w_rb;
      end
      bus.rd_data[p*DW +: DW] = w_rd;
      bus.rd_busy[p]          = w_rb;
    end
  end

  assign bus.wr_collide = r_collide;
  assign bus.busy_any   = |w_busy;

endmodule

// File: tb/tb_regfile_sb.sv
// Randomized + directed bench for regfile_sb against an array-based reference model.
module tb_regfile_sb;
  import regfile_pkg::*;

  localparam int DW    = 8;
  localparam int AW    = 4;
  localparam int NRD   = 2;
  localparam int DEPTH = 16;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  regfile_sb_if #(.DW(DW), .AW(AW), .NRD(NRD)) bus ();

  regfile_sb #(.DW(DW), .DEPTH(DEPTH), .NRD(NRD), .ZERO_REG(1)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  logic [7:0] m_mem  [DEPTH];
  bit         m_busy [DEPTH];
  bit         m_coll;
  int         total = 0;
  int         bad   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int r = 0; r < DEPTH; r++) begin
      m_mem[r]  = 8'h00;
      m_busy[r] = 1'b0;
    end
    m_coll = 1'b0;
  endtask

  // Architectural view: register 0 is zero, optional forwarding of live writes
  function automatic logic [7:0] exp_rd(input logic [3:0] a);
    if (a == 4'd0) return 8'h00;
`ifdef REGFILE_BYPASS_EN
    if (bus.we1 && bus.wa1 == a) return bus.wd1;
    if (bus.we0 && bus.wa0 == a) return bus.wd0;
`endif
    return m_mem[a];
  endfunction

  function automatic logic exp_busy(input logic [3:0] a);
    if (a == 4'd0) return 1'b0;
`ifdef REGFILE_BYPASS_EN
    if (bus.sb_set && bus.sb_addr == a) return 1'b1;
    if (bus.we1 && bus.wa1 == a) return 1'b0;
`endif
    return m_busy[a];
  endfunction

  task automatic compare_all();
    logic [3:0] a;
    bit any;
    for (int p = 0; p < NRD; p++) begin
      a = bus.rd_addr[p*AW +: AW];
      check($sformatf("rd_data%0d[r%0d]", p, a), 32'(bus.rd_data[p*DW +: DW]), 32'(exp_rd(a)));
      check($sformatf("rd_busy%0d[r%0d]", p, a), 32'(bus.rd_busy[p]), 32'(exp_busy(a)));
    end
    any = 1'b0;
    for (int r = 0; r < DEPTH; r++) any |= m_busy[r];
    check("wr_collide", 32'(bus.wr_collide), 32'(m_coll));
    check("busy_any", 32'(bus.busy_any), 32'(any));
  endtask

  // Apply one clock edge's worth of architectural effects to the model
  task automatic model_update();
    m_coll = bus.we0 && bus.we1 && (bus.wa0 == bus.wa1) && (bus.wa0 != 4'd0);
    if (bus.we0 && bus.wa0 != 4'd0) m_mem[bus.wa0] = bus.wd0;
    if (bus.we1 && bus.wa1 != 4'd0) m_mem[bus.wa1] = bus.wd1;
    if (bus.we1) m_busy[bus.wa1] = 1'b0;
    if (bus.sb_set && bus.sb_addr != 4'd0) m_busy[bus.sb_addr] = 1'b1;
  endtask

  task automatic drive(input wr_req_t w0, input wr_req_t w1, input bit s,
                       input logic [3:0] sa, input logic [3:0] a0, input logic [3:0] a1);
    bus.we0 = w0.we; bus.wa0 = w0.wa; bus.wd0 = w0.wd;
    bus.we1 = w1.we; bus.wa1 = w1.wa; bus.wd1 = w1.wd;
    bus.sb_set = s; bus.sb_addr = sa;
    bus.rd_addr = {a1, a0};
  endtask

  // Called at a falling edge with inputs set: check, take the edge, advance model
  task automatic cyc();
    #1 compare_all();
    @(posedge clk);
    model_update();
    @(negedge clk);
  endtask

  task automatic peek(input logic [3:0] a0, input logic [3:0] a1);
    drive('0, '0, 1'b0, 4'd0, a0, a1);
    #1;
  endtask

  wr_req_t nw;
  wr_req_t w0r;
  wr_req_t w1r;

  initial begin
    nw = '0;
    model_reset();
    drive(nw, nw, 1'b0, 4'd0, 4'd3, 4'd5);
    repeat (2) @(negedge clk);
    #1 compare_all();
    check("reset_r3", 32'(bus.rd_data[7:0]), 32'h00);
    @(negedge clk);
    rst_n = 1'b1;

    // Asynchronous reset mid-cycle wipes data and pending loads
    drive('{we:1'b1, wa:4'd3, wd:8'hA5}, nw, 1'b1, 4'd8, 4'd3, 4'd8);
    cyc();
    peek(4'd3, 4'd8);
    check("pre_rst_r3", 32'(bus.rd_data[7:0]), 32'hA5);
    check("pre_rst_busy8", 32'(bus.rd_busy[1]), 32'h1);
    #2 rst_n = 1'b0;
    #1;
    check("rst_r3", 32'(bus.rd_data[7:0]), 32'h00);
    check("rst_busy_any", 32'(bus.busy_any), 32'h0);
    check("rst_collide", 32'(bus.wr_collide), 32'h0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;

    // Dual write collision
    drive('{we:1'b1, wa:4'd5, wd:8'h11}, '{we:1'b1, wa:4'd5, wd:8'h22}, 1'b0, 4'd0, 4'd5, 4'd5);
    cyc();
    peek(4'd5, 4'd5);
    check("coll_r5", 32'(bus.rd_data[7:0]), 32'h22);
    check("coll_flag", 32'(bus.wr_collide), 32'h1);
    cyc();
    check("coll_flag_drop", 32'(bus.wr_collide), 32'h0);

    // Zero register ignores writes, sets and collisions
    drive('{we:1'b1, wa:4'd0, wd:8'hFF}, '{we:1'b1, wa:4'd0, wd:8'hEE}, 1'b1, 4'd0, 4'd0, 4'd0);
    cyc();
    peek(4'd0, 4'd0);
    check("zero_data", 32'(bus.rd_data[15:8]), 32'h00);
    check("zero_busy", 32'(bus.rd_busy[0]), 32'h0);
    check("zero_coll", 32'(bus.wr_collide), 32'h0);

    // Scoreboard sequence on r7
    drive(nw, nw, 1'b1, 4'd7, 4'd7, 4'd7);
    cyc();
    peek(4'd7, 4'd7);
    check("sb7_busy_p0", 32'(bus.rd_busy[0]), 32'h1);
    check("sb7_busy_p1", 32'(bus.rd_busy[1]), 32'h1);
    drive('{we:1'b1, wa:4'd7, wd:8'h33}, nw, 1'b0, 4'd0, 4'd7, 4'd7);
    cyc();
    peek(4'd7, 4'd7);
    check("sb7_alu_data", 32'(bus.rd_data[7:0]), 32'h33);
    check("sb7_alu_busy", 32'(bus.rd_busy[0]), 32'h1);
    drive(nw, '{we:1'b1, wa:4'd7, wd:8'h44}, 1'b0, 4'd0, 4'd7, 4'd7);
    cyc();
    peek(4'd7, 4'd7);
    check("sb7_ld_data", 32'(bus.rd_data[7:0]), 32'h44);
    check("sb7_ld_busy", 32'(bus.rd_busy[1]), 32'h0);

    // Set beats clear on the same register
    drive(nw, nw, 1'b1, 4'd9, 4'd9, 4'd9);
    cyc();
    drive(nw, '{we:1'b1, wa:4'd9, wd:8'h66}, 1'b1, 4'd9, 4'd9, 4'd9);
    cyc();
    peek(4'd9, 4'd9);
    check("sc9_busy", 32'(bus.rd_busy[0]), 32'h1);
    check("sc9_data", 32'(bus.rd_data[7:0]), 32'h66);

    // Same-cycle forwarding on read port 1
    drive('{we:1'b1, wa:4'd2, wd:8'h10}, nw, 1'b0, 4'd0, 4'd2, 4'd2);
    cyc();
    drive(nw, '{we:1'b1, wa:4'd2, wd:8'h5C}, 1'b0, 4'd0, 4'd1, 4'd2);
    #1;
`ifdef REGFILE_BYPASS_EN
    check("bypass_p1", 32'(bus.rd_data[15:8]), 32'h5C);
`else
    check("bypass_p1", 32'(bus.rd_data[15:8]), 32'h10);
`endif
    cyc();

    // Random traffic, biased toward address aliasing
    for (int n = 0; n < 500; n++) begin
      w0r.we = ($urandom_range(0, 3) != 0);
      w0r.wa = 4'($urandom_range(0, 15));
      w0r.wd = 8'($urandom);
      w1r.we = ($urandom_range(0, 2) != 0);
      w1r.wa = ($urandom_range(0, 3) == 0) ? w0r.wa : 4'($urandom_range(0, 15));
      w1r.wd = 8'($urandom);
      drive(w0r, w1r, ($urandom_range(0, 2) == 0), 4'($urandom_range(0, 15)),
            ($urandom_range(0, 2) == 0) ? w1r.wa : 4'($urandom_range(0, 15)),
            ($urandom_range(0, 2) == 0) ? w0r.wa : 4'($urandom_range(0, 15)));
      cyc();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
